// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared state, opcode-class, opcode and write-back encodings for the multicycle controller
package rv_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;
  typedef enum logic [2:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_LUI
  } op_class_t;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory signal bundle
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [6:0]       opcode;
  logic             branch_taken;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             addr_sel;
  logic             ir_we;
  logic             pc_we;
  logic             pc_sel;
  logic             immsel;
  logic             alu_src;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic             trap;
  logic [CNT_W-1:0] instret;
  logic [2:0]       state_o;
  modport master (
    input  opcode, branch_taken, mem_ready,
    output mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, immsel, alu_src,
           reg_we, wb_sel, trap, instret, state_o
  );
  modport slave (
    output opcode, branch_taken, mem_ready,
    input  mem_req, mem_we, addr_sel, ir_we, pc_we, pc_sel, immsel, alu_src,
           reg_we, wb_sel, trap, instret, state_o
  );
endinterface

// File: rtl/op_class_dec.sv
// op_class_dec: maps an RV32 major opcode to its instruction class and flags unknown opcodes
module op_class_dec
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_t  cls_o,
  output logic       legal_o
);
  // unknown opcodes report class R so they never raise immsel
  always_comb begin
    cls_o   = CL_R;
    legal_o = 1'b1;
    case (opcode_i)
      OP_R:      cls_o = CL_R;
      OP_I:      cls_o = CL_I;
      OP_LOAD:   cls_o = CL_LOAD;
      OP_STORE:  cls_o = CL_STORE;
      OP_BRANCH: cls_o = CL_BRANCH;
      OP_JAL:    cls_o = CL_JAL;
      OP_JALR:   cls_o = CL_JALR;
      OP_LUI:    cls_o = CL_LUI;
      default:   legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with memory-wait timeout trap and retire counter
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input logic              clk,
  input logic              rst_n,
  multicycle_ctrl_if.master bus
);
  localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);
  state_t           state_q, state_d;
  op_class_t        cls_q, dec_cls, cur_cls;
  logic             dec_legal, waiting, timeout, in_op, jump, st_wb;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] instret_q;
  op_class_dec u_dec (.opcode_i(bus.opcode), .cls_o(dec_cls), .legal_o(dec_legal));
  assign cur_cls = (state_q == ST_DECODE) ? dec_cls : cls_q;
  assign in_op   = state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB};
  assign jump    = cls_q inside {CL_JAL, CL_JALR};
  assign st_wb   = rst_n && state_q == ST_WB;
  assign waiting = (state_q inside {ST_FETCH, ST_MEM}) && !bus.mem_ready;
  assign timeout = waiting && wait_q == TMO;
  assign wait_d  = waiting ? wait_q + 1'b1 : '0;
  assign bus.instret = instret_q;
  assign bus.state_o = state_q;
  // next-state: memory waits trap only when the counter is already at the limit and ready is still low
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  state_d = bus.mem_ready ? ST_DECODE : timeout ? ST_TRAP : ST_FETCH;
      ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_TRAP;
      ST_EXEC:   state_d = (cls_q == CL_BRANCH) ? ST_FETCH :
                           (cls_q inside {CL_LOAD, CL_STORE}) ? ST_MEM : ST_WB;
      ST_MEM:    state_d = bus.mem_ready ? ((cls_q == CL_STORE) ? ST_FETCH : ST_WB) :
                           timeout ? ST_TRAP : ST_MEM;
      ST_WB:     state_d = ST_FETCH;
      default:   state_d = ST_TRAP;
    endcase
  end
  // control outputs, gated by rst_n so an in-flight access drops the moment reset asserts
  always_comb begin
    bus.mem_req  = rst_n && (state_q inside {ST_FETCH, ST_MEM});
    bus.mem_we   = rst_n && state_q == ST_MEM && cls_q == CL_STORE;
    bus.addr_sel = rst_n && state_q == ST_MEM;
    bus.ir_we    = rst_n && state_q == ST_FETCH && bus.mem_ready;
    bus.pc_we    = rst_n && ((state_q == ST_EXEC && cls_q == CL_BRANCH) ||
                             (state_q == ST_MEM && cls_q == CL_STORE && bus.mem_ready) ||
                             state_q == ST_WB);
    bus.pc_sel   = rst_n && ((state_q == ST_EXEC && cls_q == CL_BRANCH && bus.branch_taken) ||
                             (state_q == ST_WB && jump));
    bus.immsel   = rst_n && in_op && cur_cls != CL_R;
    bus.alu_src  = rst_n && in_op && cur_cls != CL_R && cur_cls != CL_BRANCH;
    bus.reg_we   = st_wb;
    bus.wb_sel   = !st_wb ? WB_ALU : (cls_q == CL_LOAD) ? WB_MEM : jump ? WB_PC4 : WB_ALU;
    bus.trap     = rst_n && state_q == ST_TRAP;
  end
  // state, latched instruction class, wait counter and retire counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      cls_q     <= CL_R;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == ST_DECODE) cls_q <= dec_cls;
      if (bus.pc_we) instret_q <= instret_q + 1'b1;
    end
endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 255, giving the maximum number of cycles to wait for mem_ready before trapping.
REQ-002 The block SHALL have parameter CNT_W, default 32, giving the width of the retired-instruction counter.
REQ-003 Port clk, input, 1: the single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port opcode, input, 7: instr[6:0] taken from the instruction register.
REQ-006 Port branch_taken, input, 1: ALU compare result, valid in EXEC.
REQ-007 Port mem_ready, input, 1: memory has completed the current request.
REQ-008 Port mem_req, output, 1: memory access request.
REQ-009 Port mem_we, output, 1: 1 = store, 0 = read.
REQ-010 Port addr_sel, output, 1: 0 = PC drives the memory address, 1 = ALU result drives it.
REQ-011 Port ir_we, output, 1: instruction register load enable.
REQ-012 Port pc_we, output, 1: PC load enable.
REQ-013 Port pc_sel, output, 1: 0 = PC+4, 1 = ALU target.
REQ-014 Port immsel, output, 1: immediate-generator select.
REQ-015 Port alu_src, output, 1: 1 = the ALU B operand is the immediate.
REQ-016 Port reg_we, output, 1: register-file write enable.
REQ-017 Port wb_sel, output, 2: write-back source; 00 ALU, 01 memory, 10 PC+4.
REQ-018 Port trap, output, 1: sticky halt indication.
REQ-019 Port instret, output, CNT_W: count of retired instructions.
REQ-020 Port state_o, output, 3: current state encoding, for debug.

Function
REQ-021 States and encodings SHALL be: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; all other encodings SHALL go to TRAP.
REQ-022 FETCH SHALL drive mem_req=1, mem_we=0 and addr_sel=0, and hold until mem_ready=1. In the ready cycle it SHALL drive ir_we=1 and go to DECODE.
REQ-023 DECODE SHALL classify opcode into R (0110011), I-ALU (0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011), JAL (1101111), JALR (1100111) and LUI (0110111).
REQ-024 In DECODE, any other opcode SHALL go to TRAP; a legal opcode SHALL go to EXEC.
REQ-025 immsel SHALL be 0 for class R and 1 for every other class, and SHALL be held from DECODE through WB.
REQ-026 alu_src SHALL equal immsel, except that BRANCH SHALL drive alu_src=0.
REQ-027 EXEC with BRANCH SHALL drive pc_we=1 and go to FETCH, with pc_sel equal to branch_taken.
REQ-028 EXEC with LOAD or STORE SHALL go to MEM; all other classes SHALL go to WB.
REQ-029 MEM SHALL drive mem_req=1 and addr_sel=1, with mem_we=1 only for STORE, and hold until mem_ready=1.
REQ-030 On mem_ready in MEM, LOAD SHALL go to WB; STORE SHALL pulse pc_we=1 with pc_sel=0 and go to FETCH.
REQ-031 WB SHALL drive reg_we=1 and pc_we=1 for one cycle, then go to FETCH.
REQ-032 In WB, wb_sel SHALL be 01 for LOAD, 10 for JAL and JALR, and 00 otherwise.
REQ-033 In WB, pc_sel SHALL be 1 for JAL and JALR, and 0 otherwise.
REQ-034 Every enable (mem_req, ir_we, pc_we, reg_we) SHALL be 0 in any state not listed above for that enable.
REQ-035 A wait counter SHALL clear on entry to FETCH and MEM and increment each cycle mem_ready=0.
REQ-036 When the wait counter reaches MEM_TIMEOUT with mem_ready still 0, the block SHALL go to TRAP on the next edge.
REQ-037 If mem_ready=1 arrives in the same cycle the counter reaches MEM_TIMEOUT, the access SHALL complete normally.
REQ-038 TRAP SHALL assert trap=1, force all enables to 0, and hold until reset.
REQ-039 instret SHALL increment by 1 on every cycle with pc_we=1, and SHALL wrap modulo 2^CNT_W.

Reset
REQ-040 rst_n=0 SHALL immediately force state=FETCH, clear the wait counter and instret, drop trap, and force every registered output to 0.
REQ-041 A reset asserted mid-access SHALL abandon the access with mem_req=0; the first request after release SHALL be a FETCH.

Structure
REQ-042 The state encodings, opcode constants and wb_sel codes SHALL live in the shared package rv_ctrl_pkg.
REQ-043 An opcode-classification decoder, sub-module op_class_dec, SHALL be instantiated once inside this block.

Verification
REQ-044 Bench SHALL run R-type add with mem_ready=1 at once -> FETCH, DECODE, EXEC, WB, with immsel=0, reg_we=1 and wb_sel=00 in WB, and instret=1.
REQ-045 Bench SHALL run LOAD with mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles with addr_sel=1, then WB with wb_sel=01.
REQ-046 Bench SHALL run BRANCH with branch_taken=1 -> pc_we=1 and pc_sel=1 in EXEC, reg_we never asserted, and a 3-cycle instruction.
REQ-047 Bench SHALL apply opcode 0000000 -> trap=1 in the cycle after DECODE, and all enables 0 for the next 20 cycles.
REQ-048 Bench SHALL run with MEM_TIMEOUT=4 and mem_ready held at 0 in FETCH -> TRAP after 5 waiting cycles; rst_n low then gives state_o=0 and trap=0.
REQ-049 Bench SHALL preload instret to all-ones via force and retire one instruction -> instret=0.
